// File: rtl/beat_grid_pkg.sv
// Shared keycode map, step-key table, decode helpers and transport state type
// for the beat grid sequencer.
package beat_grid_pkg;

   localparam logic [7:0] KEY_CH0       = 8'h1E;  // '1'; channel keys run '1'..'8'
   localparam logic [7:0] KEY_CH_LAST   = 8'h25;  // '8'
   localparam logic [7:0] KEY_CLEAR_ALL = 8'h27;  // '0'
   localparam logic [7:0] KEY_CLEAR_CH  = 8'h2A;  // Backspace
   localparam logic [7:0] KEY_SPACE     = 8'h2C;
   localparam logic [7:0] KEY_ENTER     = 8'h28;

   // Step keys Q W E R T Y U I O P [ ] A S D F; entry i is step i
   localparam logic [15:0][7:0] STEP_KEYS = {
      8'h09, 8'h07, 8'h16, 8'h04, 8'h30, 8'h2F, 8'h13, 8'h12,
      8'h0C, 8'h18, 8'h1C, 8'h17, 8'h15, 8'h08, 8'h1A, 8'h14
   };

   typedef enum logic {STOP, RUN} transport_t;

   // {valid, step index 0..15}
   function automatic logic [4:0] step_index(input logic [7:0] k);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 0; i < 16; i++)
         if (k == STEP_KEYS[i]) r = {1'b1, 4'(i)};
      return r;
   endfunction

   // {valid, channel index 0..7}
   function automatic logic [3:0] ch_index(input logic [7:0] k);
      logic [7:0] d;
      d = k - KEY_CH0;
      return (k >= KEY_CH0 && k <= KEY_CH_LAST) ? {1'b1, d[2:0]} : 4'd0;
   endfunction

endpackage

// File: rtl/beat_grid_sequencer_key_press_detect.sv
// Key press edge detector: a key acts once on the cycle its code first
// appears; holding it, or returning to 8'h00, produces nothing.
module key_press_detect (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode,
   output logic       press,
   output logic [7:0] key_code_q
);

   // Remember last cycle's keycode
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) key_code_q <= 8'h00;
      else          key_code_q <= keycode;
   end

   assign press = (keycode != 8'h00) && (keycode != key_code_q);

endmodule

// File: rtl/beat_grid_sequencer.sv
// Beat grid sequencer: HID-keyed drum pattern editor with step playback.
// Build option: define BEAT_GRID_TOGGLE_EN to make step keys toggle bits;
// otherwise step keys only set bits and the clear keys remove them.
// Reset_n is expected to be released synchronously to Clk upstream.
module beat_grid_sequencer
   import beat_grid_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int NUM_STEPS = 12,
   localparam int CH_W      = $clog2(NUM_CH)    > 0 ? $clog2(NUM_CH)    : 1,
   localparam int ST_W      = $clog2(NUM_STEPS) > 0 ? $clog2(NUM_STEPS) : 1
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic [7:0]                  keycode,
   input  logic                        step_tick,
   output logic [CH_W-1:0]             channelnum,
   output logic                        GO,
   output logic [NUM_CH*NUM_STEPS-1:0] pattern,
   output logic [ST_W-1:0]             playhead,
   output logic                        running,
   output logic [NUM_CH-1:0]           hit,
   output logic                        hit_valid
);

   logic                                  press;
   logic [7:0]                            unused_key_q;  // previous code, not needed here
   transport_t                            state_q;
   logic [NUM_CH-1:0][NUM_STEPS-1:0]      pat_q, pat_d;
   logic [CH_W-1:0]                       channelnum_q;
   logic                                  go_q;
   logic [ST_W-1:0]                       playhead_q;
   logic [NUM_CH-1:0]                     hit_q, col;
   logic                                  hit_valid_q;
   logic [4:0]                            st_dec;
   logic [3:0]                            ch_dec;
   logic [ST_W-1:0]                       st_idx;
   logic                                  ch_ok, st_ok, space_p, enter_p, clr_all_p, clr_ch_p;
   logic                                  tick_play;

   key_press_detect u_kpd (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .keycode    (keycode),
      .press      (press),
      .key_code_q (unused_key_q)
   );

   // Single-key decode; every action is qualified by a fresh press
   assign st_dec    = step_index(keycode);
   assign ch_dec    = ch_index(keycode);
   assign st_idx    = ST_W'(st_dec[3:0]);
   assign ch_ok     = press && ch_dec[3] && (int'(ch_dec[2:0]) < NUM_CH);
   assign st_ok     = press && st_dec[4] && (int'(st_dec[3:0]) < NUM_STEPS);
   assign space_p   = press && (keycode == KEY_SPACE);
   assign enter_p   = press && (keycode == KEY_ENTER);
   assign clr_all_p = press && (keycode == KEY_CLEAR_ALL);
   assign clr_ch_p  = press && (keycode == KEY_CLEAR_CH);
   // A Space press on a tick cycle suppresses the hit in both directions
   assign tick_play = step_tick && (state_q == RUN) && !space_p;

   // Next pattern: at most one edit per cycle since only one key is decoded
   always_comb begin
      pat_d = pat_q;
      if (clr_all_p)
         pat_d = '0;
      else if (clr_ch_p)
         pat_d[channelnum_q] = '0;
      else if (st_ok) begin
`ifdef BEAT_GRID_TOGGLE_EN
         pat_d[channelnum_q][st_idx] = ~pat_q[channelnum_q][st_idx];
`else
         pat_d[channelnum_q][st_idx] = 1'b1;
`endif
      end
   end

   // Column under the playhead, taken from the pre-edit pattern
   always_comb begin
      col = '0;
      for (int c = 0; c < NUM_CH; c++) col[c] = pat_q[c][playhead_q];
   end

   // Transport FSM, editor state and playback registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= STOP;
         pat_q        <= '0;
         channelnum_q <= '0;
         go_q         <= 1'b0;
         playhead_q   <= '0;
         hit_q        <= '0;
         hit_valid_q  <= 1'b0;
      end else begin
         if (space_p) state_q <= (state_q == STOP) ? RUN : STOP;
         go_q <= ch_ok;
         if (ch_ok) channelnum_q <= CH_W'(ch_dec[2:0]);
         pat_q       <= pat_d;
         hit_valid_q <= tick_play;
         if (tick_play) hit_q <= col;
         // Enter beats the tick advance, but the tick still plays the old column
         if (enter_p)
            playhead_q <= '0;
         else if (tick_play)
            playhead_q <= (playhead_q == ST_W'(NUM_STEPS - 1)) ? '0 : playhead_q + 1'b1;
      end
   end

   assign channelnum = channelnum_q;
   assign GO         = go_q;
   assign pattern    = pat_q;
   assign playhead   = playhead_q;
   assign running    = (state_q == RUN);
   assign hit        = hit_q;
   assign hit_valid  = hit_valid_q;

endmodule

// File: tb/tb_beat_grid_sequencer.sv
// Directed bench for beat_grid_sequencer (NUM_CH=4, NUM_STEPS=12): a vector
// table for editing/decode, then hand sequences for playback corner cases.
module tb_beat_grid_sequencer;

   localparam int NC = 4;
   localparam int NS = 12;

`ifdef BEAT_GRID_TOGGLE_EN
   localparam logic [47:0] W_AFTER = 48'h0;       // second W press clears ch1 step1
`else
   localparam logic [47:0] W_AFTER = 48'h2000;    // set-only: bit 13 stays
`endif

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [7:0]    keycode = 8'h00;
   logic          step_tick = 1'b0;
   logic [1:0]    channelnum;
   logic          GO;
   logic [47:0]   pattern;
   logic [3:0]    playhead;
   logic          running;
   logic [3:0]    hit;
   logic          hit_valid;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  kc;
      logic        tk;
      logic [1:0]  chn;
      logic        go;
      logic [47:0] pat;
   } vec_t;

   vec_t        tbl [16];
   logic [7:0]  sk [12];
   logic [47:0] pat_m;
   logic [3:0]  exp_hit;
   int          ph;
   int          pulses;

   beat_grid_sequencer #(.NUM_CH(NC), .NUM_STEPS(NS)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .keycode    (keycode),
      .step_tick  (step_tick),
      .channelnum (channelnum),
      .GO         (GO),
      .pattern    (pattern),
      .playhead   (playhead),
      .running    (running),
      .hit        (hit),
      .hit_valid  (hit_valid)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // One cycle: drive on the falling edge, sample 1 ns after the rising edge
   task automatic cyc(input logic [7:0] kc, input logic tk);
      @(negedge Clk);
      keycode   = kc;
      step_tick = tk;
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [3:0] column(input logic [47:0] p, input int s);
      logic [3:0] r;
      for (int c = 0; c < NC; c++) r[c] = p[c*NS + s];
      return r;
   endfunction

   initial begin
      tbl[0]  = '{8'h1F, 1'b0, 2'd1, 1'b1, 48'h0};
      tbl[1]  = '{8'h1A, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[2]  = '{8'h1A, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[3]  = '{8'h1A, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[4]  = '{8'h1A, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[5]  = '{8'h1A, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[6]  = '{8'h00, 1'b0, 2'd1, 1'b0, 48'h2000};
      tbl[7]  = '{8'h1A, 1'b0, 2'd1, 1'b0, W_AFTER};
      tbl[8]  = '{8'h00, 1'b0, 2'd1, 1'b0, W_AFTER};
      tbl[9]  = '{8'h22, 1'b0, 2'd1, 1'b0, W_AFTER};            // channel 4 >= NUM_CH
      tbl[10] = '{8'h07, 1'b0, 2'd1, 1'b0, W_AFTER};            // step 14 >= NUM_STEPS
      tbl[11] = '{8'h09, 1'b0, 2'd1, 1'b0, W_AFTER};            // step 15
      tbl[12] = '{8'h1E, 1'b0, 2'd0, 1'b1, W_AFTER};
      tbl[13] = '{8'h14, 1'b0, 2'd0, 1'b0, W_AFTER | 48'h1};
      tbl[14] = '{8'h30, 1'b0, 2'd0, 1'b0, W_AFTER | 48'h801};
      tbl[15] = '{8'h00, 1'b1, 2'd0, 1'b0, W_AFTER | 48'h801};  // tick while stopped
      sk = '{8'h14, 8'h1A, 8'h08, 8'h15, 8'h17, 8'h1C, 8'h18, 8'h0C, 8'h12, 8'h13, 8'h2F, 8'h30};

      // Reset
      repeat (3) @(posedge Clk);
      @(negedge Clk) Reset_n = 1'b1;
      @(posedge Clk); #1;
      chk("rst_pattern", pattern, 0);
      chk("rst_channelnum", channelnum, 0);
      chk("rst_playhead", playhead, 0);
      chk("rst_running", running, 0);
      chk("rst_GO", GO, 0);
      chk("rst_hit_valid", hit_valid, 0);

      // Editing / decode table
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].kc, tbl[i].tk);
         chk($sformatf("tbl%0d_channelnum", i), channelnum, tbl[i].chn);
         chk($sformatf("tbl%0d_GO", i), GO, tbl[i].go);
         chk($sformatf("tbl%0d_pattern", i), pattern, tbl[i].pat);
         chk($sformatf("tbl%0d_playhead", i), playhead, 0);
         chk($sformatf("tbl%0d_hit_valid", i), hit_valid, 0);
         chk($sformatf("tbl%0d_running", i), running, 0);
      end
      pat_m = W_AFTER | 48'h801;

      // Start playback and play 13 steps
      cyc(8'h2C, 1'b0);
      chk("space_start_running", running, 1);
      cyc(8'h00, 1'b0);
      ph = 0;
      pulses = 0;
      for (int k = 1; k <= 13; k++) begin
         exp_hit = column(pat_m, ph);
         ph = (ph + 1) % NS;
         cyc(8'h00, 1'b1);
         if (hit_valid === 1'b1) pulses++;
         chk($sformatf("tick%0d_hit", k), hit, exp_hit);
         chk($sformatf("tick%0d_playhead", k), playhead, ph);
         cyc(8'h00, 1'b0);
         if (hit_valid === 1'b1) pulses++;
         chk($sformatf("tick%0d_hit_hold", k), hit, exp_hit);
      end
      chk("hit_valid_pulses", pulses, 13);

      // Advance to playhead 3, then edit step 3 on a tick
      cyc(8'h00, 1'b1);
      cyc(8'h00, 1'b1);
      chk("pre_edit_playhead", playhead, 3);
      cyc(8'h15, 1'b1);
      chk("edit_tick_hit", hit, column(pat_m, 3));
      chk("edit_tick_hit_valid", hit_valid, 1);
      chk("edit_tick_playhead", playhead, 4);
      pat_m[3] = 1'b1;
      chk("edit_tick_pattern", pattern, pat_m);

      // Enter on a tick: plays column 4, playhead forced to 0
      cyc(8'h00, 1'b0);
      cyc(8'h17, 1'b0);
      pat_m[4] = 1'b1;
      chk("set_step4_pattern", pattern, pat_m);
      cyc(8'h00, 1'b0);
      cyc(8'h28, 1'b1);
      chk("enter_tick_playhead", playhead, 0);
      chk("enter_tick_hit", hit, column(pat_m, 4));
      chk("enter_tick_hit_valid", hit_valid, 1);
      chk("enter_tick_running", running, 1);

      // Space with tick, stopping then starting: no hit either time
      cyc(8'h2C, 1'b1);
      chk("space_stop_running", running, 0);
      chk("space_stop_hit_valid", hit_valid, 0);
      chk("space_stop_playhead", playhead, 0);
      cyc(8'h00, 1'b0);
      cyc(8'h2C, 1'b1);
      chk("space_start_tick_running", running, 1);
      chk("space_start_tick_hit_valid", hit_valid, 0);
      chk("space_start_tick_playhead", playhead, 0);

      // Clear all, fill rows 0..3, then clear row 2 and everything
      cyc(8'h27, 1'b0);
      chk("clear_all_first", pattern, 0);
      for (int c = 0; c < NC; c++) begin
         cyc(8'h1E + 8'(c), 1'b0);
         chk($sformatf("fill_sel%0d_GO", c), GO, 1);
         for (int s = 0; s < NS; s++) cyc(sk[s], 1'b0);
      end
      chk("fill_pattern", pattern, 48'hFFFF_FFFF_FFFF);
      cyc(8'h20, 1'b0);
      chk("sel_ch2", channelnum, 2);
      cyc(8'h2A, 1'b0);
      chk("clear_row2", pattern, 48'hFFF0_00FF_FFFF);
      cyc(8'h27, 1'b0);
      chk("clear_all", pattern, 0);

      // Reset in the middle of playback
      cyc(8'h14, 1'b0);
      chk("pre_reset_pattern", pattern, 48'h100_0000);
      chk("pre_reset_running", running, 1);
      @(posedge Clk);
      #3 Reset_n = 1'b0;
      #1;
      chk("midrst_running", running, 0);
      chk("midrst_pattern", pattern, 0);
      chk("midrst_channelnum", channelnum, 0);
      @(negedge Clk) Reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
